// File: rtl/ram_pkg.sv
// Shared types and default timing for the DRAM strobe/refresh arbiter.
package ram_pkg;

   localparam int unsigned CNT_W       = 3;
   localparam int unsigned DEF_RAS_CYC = 2;
   localparam int unsigned DEF_CAS_CYC = 2;
   localparam int unsigned DEF_REF_CYC = 3;
   localparam int unsigned DEF_PRE_CYC = 2;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      RAS,
      CAS,
      HOLD,
      PRE,
      RCAS,
      RRAS,
      RPRE
   } state_t;

   // A phase of N cycles loads N-1 and advances when the counter reaches 0.
   function automatic cnt_t cyc_load(input int unsigned cyc);
      return cnt_t'(cyc - 1);
   endfunction

endpackage

// File: rtl/ram_refresh_arb_if.sv
// FSB/refresh-timer request side and DRAM strobe side of the arbiter.
interface ram_refresh_arb_if;

   logic RefReq;
   logic RefUrg;
   logic BACT;
   logic RAMCS;
   logic nRAS;
   logic nCAS;
   logic RASMux;
   logic RAMReady;
   logic RefDone;

   modport master (
      output RefReq, RefUrg, BACT, RAMCS,
      input  nRAS, nCAS, RASMux, RAMReady, RefDone
   );

   modport slave (
      input  RefReq, RefUrg, BACT, RAMCS,
      output nRAS, nCAS, RASMux, RAMReady, RefDone
   );

endinterface

// File: rtl/ram_ref_track.sv
// Remembers that this RefReq period's refresh has been done; exposes Pend.
module ram_ref_track (
   input  logic clk,
   input  logic rst,
   input  logic ref_req,
   input  logic set_done,
   output logic ref_done,
   output logic pend
);

   // Clearing while RefReq is low takes precedence over a completing refresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ref_done <= 1'b0;
      else if (!ref_req)
         ref_done <= 1'b0;
      else if (set_done)
         ref_done <= 1'b1;
   end

   assign pend = ref_req && !ref_done;

endmodule

// File: rtl/ram_refresh_arb.sv
// DRAM RAS/CAS sequencer interleaving CBR refresh with CPU RAM accesses.
module ram_refresh_arb
   import ram_pkg::*;
#(
   parameter int unsigned RAS_CYC = DEF_RAS_CYC,
   parameter int unsigned CAS_CYC = DEF_CAS_CYC,
   parameter int unsigned REF_CYC = DEF_REF_CYC,
   parameter int unsigned PRE_CYC = DEF_PRE_CYC
) (
   input  logic                CLK,
   input  logic                RES,
   ram_refresh_arb_if.slave    bus
);

   state_t state, state_d, pick;
   cnt_t   cnt, cnt_d;
   logic   nras, ncas, rasmux, ready;
   logic   nras_d, ncas_d, rasmux_d, ready_d;
   logic   pend, ref_done, set_done;

   ram_ref_track u_track (
      .clk      (CLK),
      .rst      (RES),
      .ref_req  (bus.RefReq),
      .set_done (set_done),
      .ref_done (ref_done),
      .pend     (pend)
   );

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state  <= IDLE;
         cnt    <= '0;
         nras   <= 1'b1;
         ncas   <= 1'b1;
         rasmux <= 1'b1;
         ready  <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         nras   <= nras_d;
         ncas   <= ncas_d;
         rasmux <= rasmux_d;
         ready  <= ready_d;
      end
   end

   always_comb begin
      pick = IDLE;
      if (pend && bus.RefUrg)
         pick = RCAS;
      else if (bus.BACT && bus.RAMCS)
         pick = RAS;
      else if (pend)
         pick = RCAS;
   end

   // The last precharge cycle makes the idle decision itself, so a queued
   // cycle starts right after precharge without an extra idle clock.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: state_d = pick;
         RAS: begin
            if (!bus.BACT)
               state_d = PRE;
            else if (cnt == '0)
               state_d = CAS;
         end
         CAS: begin
            if (!bus.BACT)
               state_d = PRE;
            else if (cnt == '0)
               state_d = HOLD;
         end
         HOLD: begin
            if (!bus.BACT)
               state_d = PRE;
         end
         RCAS: begin
            if (cnt == '0)
               state_d = RRAS;
         end
         RRAS: begin
            if (cnt == '0)
               state_d = RPRE;
         end
         PRE, RPRE: begin
            if (cnt == '0)
               state_d = pick;
         end
         default: state_d = IDLE;
      endcase

      cnt_d = cnt;
      if (state_d != state) begin
         unique case (state_d)
            RAS:       cnt_d = cyc_load(RAS_CYC);
            CAS:       cnt_d = cyc_load(CAS_CYC);
            RRAS:      cnt_d = cyc_load(REF_CYC);
            PRE, RPRE: cnt_d = cyc_load(PRE_CYC);
            default:   cnt_d = '0;
         endcase
      end else if (cnt != '0) begin
         cnt_d = cnt - cnt_t'(1);
      end
   end

   always_comb begin
      nras_d   = 1'b1;
      ncas_d   = 1'b1;
      rasmux_d = 1'b1;
      ready_d  = 1'b0;
      unique case (state_d)
         RAS: nras_d = 1'b0;
         CAS: begin
            nras_d   = 1'b0;
            rasmux_d = 1'b0;
            ncas_d   = (state != CAS);
         end
         HOLD: begin
            nras_d   = 1'b0;
            ncas_d   = 1'b0;
            rasmux_d = 1'b0;
            ready_d  = 1'b1;
         end
         RCAS: ncas_d = 1'b0;
         RRAS: begin
            nras_d = 1'b0;
            ncas_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign set_done     = (state == RRAS) && (state_d == RPRE);

   assign bus.nRAS     = nras;
   assign bus.nCAS     = ncas;
   assign bus.RASMux   = rasmux;
   assign bus.RAMReady = ready;
   assign bus.RefDone  = ref_done;

endmodule

// File: tb/tb_ram_refresh_arb.sv
// Directed cycle-by-cycle check of strobes, RAMReady and RefDone.
module tb_ram_refresh_arb;

   logic CLK;
   logic RES;
   int unsigned errors;
   int unsigned checks;

   ram_refresh_arb_if bus ();

   ram_refresh_arb #(
      .RAS_CYC (2),
      .CAS_CYC (2),
      .REF_CYC (3),
      .PRE_CYC (2)
   ) dut (
      .CLK (CLK),
      .RES (RES),
      .bus (bus)
   );

   // {nRAS, nCAS, RASMux, RAMReady, RefDone}
   localparam logic [4:0] V_IDLE = 5'b11100;
   localparam logic [4:0] V_RCAS = 5'b10100;
   localparam logic [4:0] V_RRAS = 5'b00100;
   localparam logic [4:0] V_RAS  = 5'b01100;
   localparam logic [4:0] V_CAS1 = 5'b01000;
   localparam logic [4:0] V_CAS2 = 5'b00000;
   localparam logic [4:0] V_HOLD = 5'b00010;
   localparam logic [4:0] D      = 5'b00001;

   logic [4:0] outs;
   assign outs = {bus.nRAS, bus.nCAS, bus.RASMux, bus.RAMReady, bus.RefDone};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (nRAS nCAS RASMux RAMReady RefDone) at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic step(input string tag, input logic [4:0] exp);
      tick();
      check(tag, outs, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      errors = 0;
      checks = 0;
      RES = 1'b1;
      bus.RefReq = 1'b0;
      bus.RefUrg = 1'b0;
      bus.BACT   = 1'b0;
      bus.RAMCS  = 1'b0;
      #1;
      check("reset", outs, V_IDLE);
      tick();
      tick();
      RES = 1'b0;
      step("idle0", V_IDLE);
      step("idle1", V_IDLE);

      // Idle refresh
      bus.RefReq = 1'b1;
      step("ref_rcas", V_RCAS);
      step("ref_rras0", V_RRAS);
      step("ref_rras1", V_RRAS);
      step("ref_rras2", V_RRAS);
      step("ref_rpre0", V_IDLE | D);
      step("ref_rpre1", V_IDLE | D);
      step("ref_noagain0", V_IDLE | D);
      step("ref_noagain1", V_IDLE | D);
      step("ref_noagain2", V_IDLE | D);
      bus.RefReq = 1'b0;
      step("ref_clear", V_IDLE);
      bus.RefReq = 1'b1;
      step("ref2_rcas", V_RCAS);
      step("ref2_rras0", V_RRAS);
      step("ref2_rras1", V_RRAS);
      step("ref2_rras2", V_RRAS);
      step("ref2_rpre0", V_IDLE | D);
      step("ref2_rpre1", V_IDLE | D);

      // CPU read with no refresh pending
      bus.BACT  = 1'b1;
      bus.RAMCS = 1'b1;
      step("rd_ras0", V_RAS | D);
      step("rd_ras1", V_RAS | D);
      step("rd_cas0", V_CAS1 | D);
      step("rd_cas1", V_CAS2 | D);
      step("rd_hold0", V_HOLD | D);
      step("rd_hold1", V_HOLD | D);
      step("rd_hold2", V_HOLD | D);
      bus.BACT  = 1'b0;
      bus.RAMCS = 1'b0;
      step("rd_pre0", V_IDLE | D);
      step("rd_pre1", V_IDLE | D);
      step("rd_idle", V_IDLE | D);

      // Collision, non-urgent refresh: access first, refresh right after PRE
      bus.RefReq = 1'b0;
      step("col_clear", V_IDLE);
      bus.RefReq = 1'b1;
      bus.BACT   = 1'b1;
      bus.RAMCS  = 1'b1;
      step("col_ras0", V_RAS);
      step("col_ras1", V_RAS);
      step("col_cas0", V_CAS1);
      step("col_cas1", V_CAS2);
      step("col_hold", V_HOLD);
      bus.BACT  = 1'b0;
      bus.RAMCS = 1'b0;
      step("col_pre0", V_IDLE);
      step("col_pre1", V_IDLE);
      step("col_rcas", V_RCAS);
      step("col_rras0", V_RRAS);
      step("col_rras1", V_RRAS);
      step("col_rras2", V_RRAS);
      step("col_rpre0", V_IDLE | D);
      step("col_rpre1", V_IDLE | D);
      step("col_idle", V_IDLE | D);

      // Collision, urgent refresh: refresh first, access held off
      bus.RefReq = 1'b0;
      step("urg_clear", V_IDLE);
      bus.RefReq = 1'b1;
      bus.RefUrg = 1'b1;
      bus.BACT   = 1'b1;
      bus.RAMCS  = 1'b1;
      step("urg_rcas", V_RCAS);
      step("urg_rras0", V_RRAS);
      step("urg_rras1", V_RRAS);
      step("urg_rras2", V_RRAS);
      step("urg_rpre0", V_IDLE | D);
      step("urg_rpre1", V_IDLE | D);
      step("urg_ras0", V_RAS | D);
      step("urg_ras1", V_RAS | D);
      step("urg_cas0", V_CAS1 | D);
      step("urg_cas1", V_CAS2 | D);
      step("urg_hold", V_HOLD | D);
      bus.RefUrg = 1'b0;
      bus.BACT   = 1'b0;
      bus.RAMCS  = 1'b0;
      step("urg_pre0", V_IDLE | D);
      step("urg_pre1", V_IDLE | D);
      step("urg_idle", V_IDLE | D);

      // Abort during CAS
      bus.BACT  = 1'b1;
      bus.RAMCS = 1'b1;
      step("abc_ras0", V_RAS | D);
      step("abc_ras1", V_RAS | D);
      step("abc_cas0", V_CAS1 | D);
      bus.BACT  = 1'b0;
      bus.RAMCS = 1'b0;
      step("abc_pre0", V_IDLE | D);
      step("abc_pre1", V_IDLE | D);
      step("abc_idle0", V_IDLE | D);
      step("abc_idle1", V_IDLE | D);

      // Abort during RAS
      bus.BACT  = 1'b1;
      bus.RAMCS = 1'b1;
      step("abr_ras0", V_RAS | D);
      bus.BACT  = 1'b0;
      bus.RAMCS = 1'b0;
      step("abr_pre0", V_IDLE | D);
      step("abr_pre1", V_IDLE | D);
      step("abr_idle", V_IDLE | D);

      // RefReq drops mid-refresh: sequence intact, RefDone never set
      bus.RefReq = 1'b0;
      step("drop_clear", V_IDLE);
      bus.RefReq = 1'b1;
      step("drop_rcas", V_RCAS);
      step("drop_rras0", V_RRAS);
      bus.RefReq = 1'b0;
      step("drop_rras1", V_RRAS);
      step("drop_rras2", V_RRAS);
      step("drop_rpre0", V_IDLE);
      step("drop_rpre1", V_IDLE);
      step("drop_idle0", V_IDLE);
      step("drop_idle1", V_IDLE);

      // Async reset in HOLD, then pending refresh after release
      bus.BACT  = 1'b1;
      bus.RAMCS = 1'b1;
      step("rst_ras0", V_RAS);
      step("rst_ras1", V_RAS);
      step("rst_cas0", V_CAS1);
      step("rst_cas1", V_CAS2);
      step("rst_hold", V_HOLD);
      bus.RefReq = 1'b1;
      #2;
      RES = 1'b1;
      #1;
      check("rst_async", outs, V_IDLE);
      bus.BACT  = 1'b0;
      bus.RAMCS = 1'b0;
      #2;
      RES = 1'b0;
      step("rst_rcas", V_RCAS);
      step("rst_rras0", V_RRAS);
      step("rst_rras1", V_RRAS);
      step("rst_rras2", V_RRAS);
      step("rst_rpre0", V_IDLE | D);
      step("rst_rpre1", V_IDLE | D);
      step("rst_idle", V_IDLE | D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_refresh_arb.md
Name: ram_refresh_arb

Overview:
- Consumes the refresh timer's RefReq/RefUrg outputs and the FSB cycle-start/RAM-decode signals.
- Generates DRAM strobes: nRAS, nCAS, and the row/column address-mux select.
- Interleaves CAS-before-RAS refresh cycles with CPU RAM accesses.
- Returns RAMReady to the FSB DTACK logic.
- Sits between the refresh/startup counter and the SIMM address mux/strobe pins.

Parameters:
- RAS_CYC, 2, CLK cycles nRAS is low with row address before column phase (1..7)
- CAS_CYC, 2, CLK cycles in column phase before RAMReady asserts (1..7)
- REF_CYC, 3, CLK cycles nRAS held low during refresh (1..7)
- PRE_CYC, 2, CLK cycles of RAS precharge after any cycle (1..7)

Ports:
- CLK  in  1  FSB clock
- RES  in  1  asynchronous active-high reset
- RefReq  in  1  refresh wanted this period; low for one E-period per refresh interval
- RefUrg  in  1  refresh overdue; refresh preempts pending CPU access
- BACT  in  1  FSB bus cycle active
- RAMCS  in  1  current cycle decodes to RAM, qualified by BACT
- nRAS  out  1  row strobe, active low
- nCAS  out  1  column strobe, active low
- RASMux  out  1  1 = row address to DRAM, 0 = column
- RAMReady  out  1  RAM data valid/accepted, to DTACK logic
- RefDone  out  1  refresh completed in current RefReq period

Behaviour:
- Reset (async, RES=1): nRAS=1, nCAS=1, RASMux=1, RAMReady=0, RefDone=0, state IDLE, counter 0. All outputs are registered.
- Pend = RefReq && !RefDone.
- IDLE decision priority, evaluated each cycle:
  - Pend && RefUrg -> RCAS.
  - BACT && RAMCS -> RAS.
  - Pend -> RCAS.
  - Otherwise stay in IDLE.
- A RAM request simultaneous with a non-urgent refresh goes to the CPU.
- Access path:
  - RAS: nRAS=0, RASMux=1, for RAS_CYC cycles.
  - CAS: RASMux=0 on entry, nCAS=0 the following cycle, for CAS_CYC cycles. RAMReady=1 is registered on the last CAS cycle.
  - HOLD: strobes and RAMReady held until BACT=0.
  - On BACT=0 -> PRE.
  - Latency: first RAMReady high RAS_CYC+CAS_CYC+1 cycles after IDLE samples the request.
- Abort: BACT=0 while in RAS or CAS -> PRE next cycle. RAMReady is never asserted for an aborted cycle.
- Refresh path:
  - RCAS: nCAS=0, nRAS=1, 1 cycle.
  - RRAS: nRAS=0, nCAS=0, for REF_CYC cycles.
  - RPRE: both strobes high, RefDone set on entry.
- PRE/RPRE: nRAS=nCAS=1, RASMux=1, RAMReady=0, for PRE_CYC cycles, then IDLE. No new cycle may start before precharge completes.
- A RAM request arriving during refresh is held off (RAMReady=0) and is served from IDLE after RPRE. BACT stays high, so it is not lost.
- RefDone clear: synchronously while RefReq=0. Clear wins over set on the same cycle.
- A refresh in flight when RefReq drops still completes, with strobe sequence intact.
- Counter: one shared 3-bit down-counter, loaded with (param-1) on state entry; the state advances at 0.
- nCAS low with nRAS high occurs only in RCAS.
- Async reset mid-cycle returns all strobes high immediately.

Decomposition:
- Package ram_pkg:
  - state enum {IDLE, RAS, CAS, HOLD, PRE, RCAS, RRAS, RPRE}
  - default timing constants
  - counter width constant (3)
- Sub-module ram_ref_track: RefDone set/clear latch plus Pend output. It is small, but is isolated for reuse by a future second RAM bank.

Test Plan:
- Idle refresh: RefReq 0->1 with BACT=0 -> nCAS low 1 cycle, then nRAS low 3 cycles with nCAS low, then 2 precharge cycles. RefDone=1 at RPRE entry. No second refresh until RefReq falls and rises.
- CPU read: BACT=RAMCS=1 in IDLE, Pend=0 -> nRAS low at +1, RASMux=0 at +3, RAMReady=1 at +5. Hold until BACT drops, then strobes high and 2 precharge cycles.
- Collision: RAM request and non-urgent Pend in the same cycle -> access first, then refresh starts immediately after PRE. The same collision with RefUrg=1 -> refresh first, and RAMReady is delayed by 1+3+2 cycles.
- Abort: BACT falls during the CAS phase -> PRE next cycle, RAMReady stays 0 throughout.
- RefReq low during RRAS -> refresh completes normally, RefDone stays 0 that cycle and after.
- Async RES pulse during HOLD -> nRAS=nCAS=1 and RAMReady=0 immediately. After release, IDLE; a pending RefReq triggers refresh.
